// File: rtl/query_row_bank_ring.sv
// Ring of NUM_BANKS query row banks: the aggregator fills banks in order while
// the matcher random-reads the oldest completed bank, then releases it.
module query_row_bank_ring #(
  parameter int DATA_WIDTH = 55,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_W     = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fsm_enable,
  input  logic [ADDR_WIDTH:0]   row_len,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic [BANK_W-1:0]     wr_bank,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic                  rd_bank_ready,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [BANK_W:0]       full_count
);
  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_state_e;

  bank_state_e           state_q [NUM_BANKS];
  bank_state_e           state_d [NUM_BANKS];
  logic [LEN_W-1:0]      len_q   [NUM_BANKS];
  logic [LEN_W-1:0]      len_d   [NUM_BANKS];
  logic [BANK_W-1:0]     wbank_q, wbank_d;
  logic [BANK_W-1:0]     rbank_q, rbank_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_err_q, rd_err_d;
  logic [BANK_W:0]       full_count_q, full_count_d;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] cur_len;
  logic             wr_fire;
  logic             wr_last;
  logic             rd_ready;
  logic             rd_fire;
  logic             rd_oob;
  logic             rel_fire;

  // 0 and anything beyond DEPTH both mean a full-depth row
  assign eff_len  = (row_len == '0 || row_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : row_len;
  assign cur_len  = (wcnt_q == '0) ? eff_len : len_q[wbank_q];
  assign wr_ready = ~rst & fsm_enable & (state_q[wbank_q] == BANK_EMPTY);
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_last  = (LEN_W'(wcnt_q) == cur_len - LEN_W'(1));
  assign rd_ready = (state_q[rbank_q] == BANK_FULL);
  assign rd_fire  = rd_en & rd_ready;
  assign rd_oob   = (LEN_W'(rd_addr) >= len_q[rbank_q]);
  assign rel_fire = rd_done & rd_ready;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wbank_q][wcnt_q] <= wr_data;
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wbank_d      = wbank_q;
    rbank_d      = rbank_q;
    wcnt_d       = wcnt_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_fire;
    rd_err_d     = rd_err_q;
    full_count_d = full_count_q + (BANK_W+1)'(wr_fire & wr_last) - (BANK_W+1)'(rel_fire);

    if (wr_fire) begin
      if (wcnt_q == '0) len_d[wbank_q] = eff_len;
      if (wr_last) begin
        state_d[wbank_q] = BANK_FULL;
        wbank_d          = wbank_q + BANK_W'(1);
        wcnt_d           = '0;
      end else begin
        wcnt_d = wcnt_q + ADDR_WIDTH'(1);
      end
    end

    // The written bank is EMPTY and the released one FULL, so these never collide
    if (rel_fire) begin
      state_d[rbank_q] = BANK_EMPTY;
      rbank_d          = rbank_q + BANK_W'(1);
    end

    if (rd_fire) begin
      if (rd_oob) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else begin
        rd_data_d = mem[rbank_q][rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= '{default: BANK_EMPTY};
      len_q        <= '{default: '0};
      wbank_q      <= '0;
      rbank_q      <= '0;
      wcnt_q       <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      full_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      wcnt_q       <= wcnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
      full_count_q <= full_count_d;
    end
  end

  assign wr_bank       = wbank_q;
  assign rd_bank       = rbank_q;
  assign rd_bank_ready = rd_ready;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign rd_err        = rd_err_q;
  assign full_count    = full_count_q;

endmodule

// File: tb/tb_query_row_bank_ring.sv
// Bench for query_row_bank_ring: directed scenarios followed by random traffic,
// checked against a ring-occupancy model of completed rows.
module tb_query_row_bank_ring;
  localparam int DW    = 55;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
  localparam int NB    = 2;
  localparam int BW    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          fsm_enable;
  logic [AW:0]   row_len;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [BW-1:0] wr_bank;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_done;
  logic          rd_bank_ready;
  logic [BW-1:0] rd_bank;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;
  logic [BW:0]   full_count;

  always #5 clk = ~clk;

  query_row_bank_ring #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .rst(rst), .fsm_enable(fsm_enable), .row_len(row_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_bank_ready(rd_bank_ready), .rd_bank(rd_bank), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .full_count(full_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: rows complete into a FIFO of banks; the write bank is
  // always the one just after the queued full rows.
  logic [DW-1:0] m_mem [NB][DEPTH];
  int            m_len [NB];
  int            m_rb, m_full, m_wcnt, m_curlen;
  logic          m_err, m_valid;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_len(input int rl);
    return (rl == 0 || rl > DEPTH) ? DEPTH : rl;
  endfunction

  task automatic model_reset();
    m_rb = 0; m_full = 0; m_wcnt = 0; m_curlen = 0;
    m_err = 1'b0; m_valid = 1'b0; m_data = '0;
  endtask

  task automatic step();
    int wb;
    bit acc, rdf, rel;
    #1;
    check("wr_ready", 64'(wr_ready), 64'(fsm_enable && m_full < NB));
    check("rd_bank_ready", 64'(rd_bank_ready), 64'(m_full > 0));
    check("wr_bank", 64'(wr_bank), 64'((m_rb + m_full) % NB));
    check("rd_bank", 64'(rd_bank), 64'(m_rb));
    check("full_count", 64'(full_count), 64'(m_full));
    wb  = (m_rb + m_full) % NB;
    acc = wr_valid && fsm_enable && (m_full < NB);
    rdf = rd_en && (m_full > 0);
    rel = rd_done && (m_full > 0);
    m_valid = rdf;
    if (rdf) begin
      if (int'(rd_addr) >= m_len[m_rb]) begin
        m_data = '0;
        m_err  = 1'b1;
      end else begin
        m_data = m_mem[m_rb][rd_addr];
      end
    end
    if (acc) begin
      if (m_wcnt == 0) m_curlen = eff_len(int'(row_len));
      m_mem[wb][m_wcnt] = wr_data;
      if (m_wcnt == m_curlen - 1) begin
        m_len[wb] = m_curlen;
        m_full++;
        m_wcnt = 0;
      end else begin
        m_wcnt++;
      end
    end
    if (rel) begin
      m_rb = (m_rb + 1) % NB;
      m_full--;
    end
    @(posedge clk);
    #1;
    check("rd_valid", 64'(rd_valid), 64'(m_valid));
    check("rd_data", 64'(rd_data), 64'(m_data));
    check("rd_err", 64'(rd_err), 64'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_wr_ready", 64'(wr_ready), 64'(0));
    check("rst_full_count", 64'(full_count), 64'(0));
    check("rst_rd_bank_ready", 64'(rd_bank_ready), 64'(0));
    check("rst_wr_bank", 64'(wr_bank), 64'(0));
    check("rst_rd_bank", 64'(rd_bank), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_rd_err", 64'(rd_err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write_row(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(base + i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) m_len[b] = 0;
    fsm_enable = 1'b1; row_len = 8'd5; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    do_reset();

    // Basic fill then back-to-back reads
    write_row(5, 0);
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      step();
    end
    rd_en = 1'b0;

    // Fill the second bank, then push against a full ring
    write_row(5, 100);
    wr_valid = 1'b1; wr_data = DW'(999);
    step();
    wr_valid = 1'b0;
    rd_en = 1'b1; rd_addr = AW'(7);
    step();
    rd_en = 1'b0;
    step();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    step();

    // Read and release in the same cycle, then requests with nothing FULL
    rd_en = 1'b1; rd_addr = AW'(2); rd_done = 1'b1;
    step();
    rd_addr = AW'(0); rd_done = 1'b0;
    step();
    rd_en = 1'b0; rd_done = 1'b1;
    step();
    rd_done = 1'b0;

    // Full-depth row via row_len = 0
    do_reset();
    row_len = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = DW'({$urandom, $urandom});
      step();
    end
    wr_valid = 1'b0;
    rd_en = 1'b1;
    rd_addr = AW'(0);   step();
    rd_addr = AW'(127); step();
    rd_addr = AW'(64);  step();
    rd_en = 1'b0; rd_done = 1'b1;
    step();
    rd_done = 1'b0;

    // row_len change mid-row applies only to the next row
    row_len = 8'd5;
    write_row(2, 300);
    row_len = 8'd3;
    write_row(3, 302);
    write_row(3, 400);
    rd_en = 1'b1; rd_addr = AW'(4);
    step();
    rd_done = 1'b1; rd_addr = AW'(2);
    step();
    rd_addr = AW'(3);
    step();
    rd_en = 1'b0; rd_done = 1'b0;

    // Asynchronous reset mid-row with bank 0 FULL
    do_reset();
    row_len = 8'd4;
    write_row(4, 500);
    write_row(2, 600);
    do_reset();
    row_len = 8'd1;
    write_row(1, 777);
    rd_en = 1'b1; rd_addr = AW'(0);
    step();
    rd_en = 1'b0; rd_done = 1'b1;
    step();
    rd_done = 1'b0;

    // Random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      fsm_enable = ($urandom_range(0, 9) != 0);
      wr_valid   = ($urandom_range(0, 3) != 0);
      wr_data    = DW'({$urandom, $urandom});
      r = $urandom_range(0, 39);
      if (r < 37)      row_len = 8'($urandom_range(1, 8));
      else if (r < 39) row_len = '0;
      else             row_len = 8'($urandom_range(129, 255));
      rd_en   = $urandom_range(0, 1) != 0;
      rd_addr = ($urandom_range(0, 31) == 0) ? AW'($urandom_range(0, 127)) : AW'($urandom_range(0, 7));
      rd_done = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
